// File: rtl/scc_axi_pkg.sv
// rtl/scc_axi_pkg.sv - shared AXI types and constants for the SCC AXI masters
package scc_axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  localparam int         AXI_BOUNDARY_BYTES = 4096;
  localparam logic [3:0] AXI_CACHE_DEFAULT  = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } wr_state_e;

endpackage

// File: rtl/scc_axi_burst_calc.sv
// rtl/scc_axi_burst_calc.sv - burst length = min(remaining, max burst, beats left in the 4 KB page)
module scc_axi_burst_calc
  import scc_axi_pkg::*;
#(
  parameter int DATA_WIDTH    = 128,
  parameter int LEN_WIDTH     = 16,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic [11:0]          addr_lo_i,
  input  logic [LEN_WIDTH-1:0] remaining_i,
  output logic [8:0]           len_o
);

  localparam int SIZE = $clog2(DATA_WIDTH / 8);
  localparam int CW   = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

  logic [12:0]   room_bytes;
  logic [CW-1:0] room_beats;
  logic [CW-1:0] len;

  // Address is beat-aligned, so the page always has room for at least one beat.
  always_comb begin
    room_bytes = 13'(AXI_BOUNDARY_BYTES) - {1'b0, addr_lo_i};
    room_beats = CW'(room_bytes >> SIZE);
    len        = CW'(remaining_i);
    if (CW'(MAX_BURST_LEN) < len) len = CW'(MAX_BURST_LEN);
    if (room_beats < len) len = room_beats;
    len_o = len[8:0];
  end

endmodule

// File: rtl/scc_axi_wr_master.sv
// rtl/scc_axi_wr_master.sv - AXI4 write initiator streaming a job into the SCC input buffer
module scc_axi_wr_master
  import scc_axi_pkg::*;
#(
  parameter int DATA_WIDTH    = 128,
  parameter int ADDR_WIDTH    = 32,
  parameter int ID_WIDTH      = 8,
  parameter int AXI_ID        = 0,
  parameter int MAX_BURST_LEN = 16,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [LEN_WIDTH-1:0]    total_beats_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  input  logic [DATA_WIDTH-1:0]   s_data_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic [3:0]              m_axi_awregion,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);

  localparam int                    BYTES      = DATA_WIDTH / 8;
  localparam int                    SIZE       = $clog2(BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);

  wr_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [8:0]            len_q, len_d;
  logic [8:0]            beat_q, beat_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [ADDR_WIDTH-1:0] base_aligned;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [LEN_WIDTH-1:0]  next_rem;
  logic [11:0]           calc_addr_lo;
  logic [LEN_WIDTH-1:0]  calc_rem;
  logic [8:0]            calc_len;
  logic                  w_fire;
  logic                  b_err;

  assign base_aligned = base_addr_i & ALIGN_MASK;
  assign next_addr    = addr_q + (ADDR_WIDTH'(len_q) << SIZE);
  assign next_rem     = rem_q - LEN_WIDTH'(len_q);

  // The calculator sees the job start in IDLE and the following burst everywhere else.
  assign calc_addr_lo = (state_q == ST_IDLE) ? base_aligned[11:0] : next_addr[11:0];
  assign calc_rem     = (state_q == ST_IDLE) ? total_beats_i : next_rem;

  scc_axi_burst_calc #(
    .DATA_WIDTH   (DATA_WIDTH),
    .LEN_WIDTH    (LEN_WIDTH),
    .MAX_BURST_LEN(MAX_BURST_LEN)
  ) u_burst_calc (
    .addr_lo_i  (calc_addr_lo),
    .remaining_i(calc_rem),
    .len_o      (calc_len)
  );

  assign m_axi_awid     = ID_WIDTH'(AXI_ID);
  assign m_axi_awaddr   = addr_q;
  assign m_axi_awlen    = 8'(len_q - 9'd1);
  assign m_axi_awsize   = 3'(SIZE);
  assign m_axi_awburst  = BURST_INCR;
  assign m_axi_awlock   = 1'b0;
  assign m_axi_awcache  = AXI_CACHE_DEFAULT;
  assign m_axi_awprot   = 3'b000;
  assign m_axi_awqos    = 4'b0000;
  assign m_axi_awregion = 4'b0000;
  assign m_axi_awvalid  = (state_q == ST_ADDR);

  assign m_axi_wdata  = s_data_i;
  assign m_axi_wstrb  = '1;
  assign m_axi_wlast  = (state_q == ST_DATA) && (beat_q == len_q - 9'd1);
  assign m_axi_wvalid = (state_q == ST_DATA) && s_valid_i;
  assign s_ready_o    = (state_q == ST_DATA) && m_axi_wready;
  assign m_axi_bready = (state_q == ST_RESP);

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = done_q;
  assign err_o  = err_q;

  assign w_fire = m_axi_wvalid && m_axi_wready;
  assign b_err  = (m_axi_bresp != RESP_OKAY) || (m_axi_bid != ID_WIDTH'(AXI_ID));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    len_d   = len_q;
    beat_d  = beat_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (total_beats_i != '0) begin
            addr_d  = base_aligned;
            rem_d   = total_beats_i;
            len_d   = calc_len;
            beat_d  = '0;
            state_d = ST_ADDR;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (m_axi_awready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (w_fire) begin
          beat_d = beat_q + 9'd1;
          if (m_axi_wlast) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (m_axi_bvalid) begin
          // An errored response aborts the job even if beats remain.
          if (b_err || next_rem == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            err_d   = b_err;
          end else begin
            addr_d  = next_addr;
            rem_d   = next_rem;
            len_d   = calc_len;
            beat_d  = '0;
            state_d = ST_ADDR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_scc_axi_wr_master.sv
// tb/tb_scc_axi_wr_master.sv - scoreboard bench for scc_axi_wr_master
module tb_scc_axi_wr_master;

  localparam int DW     = 128;
  localparam int AW     = 32;
  localparam int IW     = 8;
  localparam int LW     = 16;
  localparam int AXI_ID = 0;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start_i = 1'b0;
  logic [AW-1:0]   base_addr_i = '0;
  logic [LW-1:0]   total_beats_i = '0;
  logic            busy_o, done_o, err_o;
  logic [DW-1:0]   s_data_i = '0;
  logic            s_valid_i = 1'b0;
  logic            s_ready_o;
  logic [IW-1:0]   awid;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awlock;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic [3:0]      awqos;
  logic [3:0]      awregion;
  logic            awvalid;
  logic            awready = 1'b0;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast, wvalid;
  logic            wready = 1'b0;
  logic [IW-1:0]   bid = '0;
  logic [1:0]      bresp = 2'b00;
  logic            bvalid = 1'b0;
  logic            bready;

  always #5 clk = ~clk;

  scc_axi_wr_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .AXI_ID(AXI_ID),
    .MAX_BURST_LEN(16), .LEN_WIDTH(LW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
    .total_beats_i(total_beats_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awregion(awregion),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
  );

  typedef struct packed { logic [AW-1:0] addr; logic [7:0] len; } aw_t;
  typedef struct packed { logic [DW-1:0] data; logic last; } w_t;

  aw_t           exp_aw_q[$];
  w_t            exp_w_q[$];
  logic [DW-1:0] stream_q[$];
  logic [1:0]    bresp_q[$];

  int checks = 0, failures = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, last_b_cyc = 0, b_cnt = 0, w_beats = 0, aw_cnt = 0;
  int aw_outstanding = 0, b_pending = 0, aw_stall_cfg = 0, aw_stall_left = 0;
  bit done_err = 0, done_busy = 0, gap_mode = 0, wready_toggle = 0;
  bit w_hs_prev = 0, b_hs_prev = 0, aw_hold_valid = 0;
  logic [AW-1:0] held_addr;
  logic [7:0]    held_len;

  task automatic push_burst(input logic [AW-1:0] addr, input int beats);
    aw_t a;
    w_t  w;
    logic [DW-1:0] d;
    a.addr = addr;
    a.len  = 8'(beats - 1);
    exp_aw_q.push_back(a);
    for (int i = 0; i < beats; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      stream_q.push_back(d);
      w.data = d;
      w.last = (i == beats - 1);
      exp_w_q.push_back(w);
    end
  endtask

  // AXI slave, stream source and scoreboard; drives at negedge, judges handshakes 1 ns later
  initial begin
    aw_t a;
    w_t  w;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        s_valid_i = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        w_hs_prev = 0; b_hs_prev = 0; aw_hold_valid = 0;
        continue;
      end
      if (!(s_valid_i && !w_hs_prev)) begin
        if (stream_q.size() > 0 && (!gap_mode || $urandom_range(0, 2) != 0)) begin
          s_valid_i = 1'b1;
          s_data_i  = stream_q.pop_front();
        end else begin
          s_valid_i = 1'b0;
        end
      end
      awready = (aw_stall_left == 0);
      wready  = wready_toggle ? ~wready : 1'b1;
      if (b_hs_prev) bvalid = 1'b0;
      if (!bvalid && b_pending > 0) begin
        bvalid = 1'b1;
        bresp  = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
        bid    = IW'(AXI_ID);
      end
      #1;
      w_hs_prev = 0;
      b_hs_prev = 0;
      if (awvalid && awready) begin
        aw_cnt++;
        checks++;
        if (exp_aw_q.size() == 0) begin
          failures++;
          $display("FAIL aw_unexpected: awaddr=%h awlen=%0d, required no AW", awaddr, awlen);
        end else begin
          a = exp_aw_q.pop_front();
          if (awaddr !== a.addr || awlen !== a.len) begin
            failures++;
            $display("FAIL aw_payload: awaddr=%h awlen=%0d, required awaddr=%h awlen=%0d",
                     awaddr, awlen, a.addr, a.len);
          end
        end
        checks++;
        if ({awid, awsize, awburst, awlock, awcache, awprot, awqos, awregion} !==
            {IW'(AXI_ID), 3'd4, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0, 4'h0}) begin
          failures++;
          $display("FAIL aw_const: id=%h size=%0d burst=%0d lock=%0d cache=%h prot=%0d qos=%0d region=%0d, required 0/4/1/0/3/0/0/0",
                   awid, awsize, awburst, awlock, awcache, awprot, awqos, awregion);
        end
        checks++;
        if (aw_outstanding != 0 || b_pending != 0) begin
          failures++;
          $display("FAIL aw_outstanding: %0d bursts open, required 0", aw_outstanding + b_pending);
        end
        aw_outstanding++;
        aw_hold_valid = 0;
        aw_stall_left = aw_stall_cfg;
      end else if (awvalid) begin
        if (aw_hold_valid) begin
          checks++;
          if (awaddr !== held_addr || awlen !== held_len) begin
            failures++;
            $display("FAIL aw_stable: awaddr=%h awlen=%0d, required awaddr=%h awlen=%0d",
                     awaddr, awlen, held_addr, held_len);
          end
        end
        held_addr = awaddr;
        held_len  = awlen;
        aw_hold_valid = 1;
        if (aw_stall_left > 0) aw_stall_left--;
      end
      if (wvalid && wready) begin
        w_hs_prev = 1;
        w_beats++;
        checks++;
        if (aw_outstanding == 0) begin
          failures++;
          $display("FAIL w_before_aw: W beat with %0d accepted AW, required 1", aw_outstanding);
        end
        checks++;
        if (exp_w_q.size() == 0) begin
          failures++;
          $display("FAIL w_unexpected: wdata=%h, required no beat", wdata);
        end else begin
          w = exp_w_q.pop_front();
          if (wdata !== w.data || wlast !== w.last || wstrb !== '1) begin
            failures++;
            $display("FAIL w_beat: wdata=%h wlast=%b wstrb=%h, required wdata=%h wlast=%b wstrb=all ones",
                     wdata, wlast, wstrb, w.data, w.last);
          end
        end
        if (wlast && aw_outstanding > 0) begin
          aw_outstanding--;
          b_pending++;
        end
      end
      if (bvalid && bready) begin
        b_hs_prev = 1;
        b_cnt++;
        last_b_cyc = cyc;
        if (b_pending > 0) b_pending--;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc  = cyc;
        done_err  = err_o;
        done_busy = busy_o;
      end
      if (err_o) begin
        checks++;
        if (!done_o) begin
          failures++;
          $display("FAIL err_without_done: err_o=1 done_o=0, required done_o=1");
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  task automatic start_job(input logic [AW-1:0] base, input int beats);
    @(negedge clk);
    start_i       = 1'b1;
    base_addr_i   = base;
    total_beats_i = LW'(beats);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int base_cnt = done_cnt;
    int n = 0;
    while (done_cnt == base_cnt && n < 3000) begin
      @(negedge clk);
      #2;
      n++;
    end
    checks++;
    if (done_cnt == base_cnt) begin
      failures++;
      $display("FAIL %s_timeout: no done_o after %0d cycles, required one pulse", name, n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if ({awvalid, wvalid, bready, s_ready_o, busy_o, done_o, err_o} !== 7'b0) begin
      failures++;
      $display("FAIL reset_state: aw/w/b/sready/busy/done/err=%b, required 0000000",
               {awvalid, wvalid, bready, s_ready_o, busy_o, done_o, err_o});
    end
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_multi_burst();
    int d0 = done_cnt, b0 = b_cnt, w0 = w_beats;
    push_burst(32'h1000, 16);
    push_burst(32'h1100, 16);
    push_burst(32'h1200, 8);
    start_job(32'h1000, 40);
    wait_done("multi");
    repeat (5) @(negedge clk);
    #2;
    checks++;
    if (done_cnt != d0 + 1 || done_err || done_busy) begin
      failures++;
      $display("FAIL multi_done: pulses=%0d err=%0d busy=%0d, required 1/0/0", done_cnt - d0, done_err, done_busy);
    end
    checks++;
    if (b_cnt - b0 != 3 || done_cyc != last_b_cyc + 1) begin
      failures++;
      $display("FAIL multi_b: B count=%0d done lag=%0d, required 3 and 1", b_cnt - b0, done_cyc - last_b_cyc);
    end
    checks++;
    if (w_beats - w0 != 40 || exp_aw_q.size() != 0 || exp_w_q.size() != 0) begin
      failures++;
      $display("FAIL multi_beats: beats=%0d aw left=%0d w left=%0d, required 40/0/0",
               w_beats - w0, exp_aw_q.size(), exp_w_q.size());
    end
  endtask

  task automatic test_4k_boundary();
    int d0 = done_cnt, a0 = aw_cnt;
    push_burst(32'h1FC0, 4);
    push_burst(32'h2000, 4);
    start_job(32'h1FC0, 8);
    wait_done("boundary");
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (aw_cnt - a0 != 2 || exp_aw_q.size() != 0 || exp_w_q.size() != 0 || done_cnt != d0 + 1 || done_err) begin
      failures++;
      $display("FAIL boundary: aw=%0d aw left=%0d w left=%0d pulses=%0d err=%0d, required 2/0/0/1/0",
               aw_cnt - a0, exp_aw_q.size(), exp_w_q.size(), done_cnt - d0, done_err);
    end
  endtask

  task automatic test_zero_len();
    int d0 = done_cnt, a0 = aw_cnt;
    @(negedge clk);
    start_i = 1'b1;
    base_addr_i = 32'h1234;
    total_beats_i = '0;
    @(negedge clk);
    start_i = 1'b0;
    #2;
    checks++;
    if (done_o !== 1'b1 || err_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL zero_done: done=%b err=%b busy=%b, required 1/0/0", done_o, err_o, busy_o);
    end
    @(negedge clk);
    #2;
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL zero_pulse: done=%b busy=%b one cycle later, required 0/0", done_o, busy_o);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (aw_cnt != a0 || done_cnt != d0 + 1) begin
      failures++;
      $display("FAIL zero_traffic: aw=%0d pulses=%0d, required 0/1", aw_cnt - a0, done_cnt - d0);
    end
  endtask

  task automatic test_slverr();
    int d0 = done_cnt, a0 = aw_cnt;
    bresp_q.push_back(2'b10);
    push_burst(32'h4000, 16);
    start_job(32'h4000, 40);
    wait_done("slverr");
    repeat (20) @(negedge clk);
    #2;
    checks++;
    if (done_cnt != d0 + 1 || !done_err || done_busy || done_cyc != last_b_cyc + 1) begin
      failures++;
      $display("FAIL slverr_done: pulses=%0d err=%0d busy=%0d lag=%0d, required 1/1/0/1",
               done_cnt - d0, done_err, done_busy, done_cyc - last_b_cyc);
    end
    checks++;
    if (aw_cnt - a0 != 1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL slverr_abort: aw=%0d busy=%b, required 1/0", aw_cnt - a0, busy_o);
    end
  endtask

  task automatic test_back_pressure();
    int d0 = done_cnt, a0 = aw_cnt, c0 = checks;
    aw_stall_cfg = 5;
    aw_stall_left = 5;
    gap_mode = 1;
    wready_toggle = 1;
    push_burst(32'h3F80, 8);
    push_burst(32'h4000, 16);
    start_job(32'h3F80, 24);
    repeat (2) @(negedge clk);
    start_i = 1'b1;
    base_addr_i = 32'h9000;
    total_beats_i = LW'(4);
    @(negedge clk);
    start_i = 1'b0;
    wait_done("bp");
    repeat (5) @(negedge clk);
    #2;
    checks++;
    if (aw_cnt - a0 != 2 || done_cnt != d0 + 1 || done_err || exp_w_q.size() != 0 || exp_aw_q.size() != 0) begin
      failures++;
      $display("FAIL bp_job: aw=%0d pulses=%0d err=%0d w left=%0d aw left=%0d, required 2/1/0/0/0",
               aw_cnt - a0, done_cnt - d0, done_err, exp_w_q.size(), exp_aw_q.size());
    end
    checks++;
    if (checks - c0 < 40) begin
      failures++;
      $display("FAIL bp_coverage: %0d scoreboard checks, required at least 40 incl. held AW", checks - c0);
    end
    aw_stall_cfg = 0;
    aw_stall_left = 0;
    gap_mode = 0;
    wready_toggle = 0;
  endtask

  task automatic test_reset_mid();
    int d0 = done_cnt, w0 = w_beats, n = 0, d1;
    push_burst(32'h5000, 16);
    start_job(32'h5000, 16);
    while (w_beats < w0 + 7 && n < 500) begin
      @(negedge clk);
      #2;
      n++;
    end
    checks++;
    if (w_beats < w0 + 7) begin
      failures++;
      $display("FAIL rst_mid_wait: beats=%0d, required 7", w_beats - w0);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({awvalid, wvalid, bready, busy_o, s_ready_o} !== 5'b0) begin
      failures++;
      $display("FAIL rst_mid_drop: aw/w/b/busy/sready=%b, required 00000",
               {awvalid, wvalid, bready, busy_o, s_ready_o});
    end
    exp_aw_q.delete();
    exp_w_q.delete();
    stream_q.delete();
    bresp_q.delete();
    aw_outstanding = 0;
    b_pending = 0;
    repeat (3) @(negedge clk);
    #3;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (done_cnt != d0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_nodone: pulses=%0d busy=%b, required 0/0", done_cnt - d0, busy_o);
    end
    d1 = done_cnt;
    push_burst(32'h6000, 4);
    start_job(32'h600C, 4);
    wait_done("rst_recover");
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (done_cnt != d1 + 1 || done_err || exp_aw_q.size() != 0 || exp_w_q.size() != 0) begin
      failures++;
      $display("FAIL rst_recover: pulses=%0d err=%0d aw left=%0d w left=%0d, required 1/0/0/0",
               done_cnt - d1, done_err, exp_aw_q.size(), exp_w_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_multi_burst();
    test_4k_boundary();
    test_zero_len();
    test_slverr();
    test_back_pressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scc_axi_wr_master.md
Name: scc_axi_wr_master

Overview:
- AXI4 write initiator that streams 128-bit words into the SCC input data buffer, acting as the AXI slave's write-side counterpart.
- Accepts a job (base address, beat count) plus a valid/ready data stream.
- Splits the job into INCR bursts, never crossing a 4 KB boundary, and checks each write response.
- Sits between the host/test DMA fabric and the SCC AXI write slave port.

Parameters:
DATA_WIDTH, 128, AXI data width in bits; power of two, ≥32.
ADDR_WIDTH, 32, AXI address width.
ID_WIDTH, 8, AXI ID width.
AXI_ID, 0, constant AWID driven; expected BID.
MAX_BURST_LEN, 16, max beats per burst (1..256).
LEN_WIDTH, 16, width of job beat count.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  job start pulse; ignored while busy_o=1
base_addr_i  in  ADDR_WIDTH  job byte address; low log2(DATA_WIDTH/8) bits forced to 0
total_beats_i  in  LEN_WIDTH  job length in beats
busy_o  out  1  job in progress
done_o  out  1  one-cycle pulse at job end
err_o  out  1  one-cycle pulse coincident with done_o if any BRESP≠OKAY or BID≠AXI_ID
s_data_i  in  DATA_WIDTH  stream data
s_valid_i  in  1  stream valid
s_ready_o  out  1  stream ready
m_axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awqos/awregion  out  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3/4/4  AW payload
m_axi_awvalid  out  1;  m_axi_awready  in  1
m_axi_wdata  out  DATA_WIDTH;  m_axi_wstrb  out  DATA_WIDTH/8;  m_axi_wlast  out  1
m_axi_wvalid  out  1;  m_axi_wready  in  1
m_axi_bid  in  ID_WIDTH;  m_axi_bresp  in  2;  m_axi_bvalid  in  1;  m_axi_bready  out  1

Behaviour:
- Single clock clk_i; rst_ni asynchronous active-low.
- Reset values (state IDLE): awvalid/wvalid/bready/s_ready_o/busy_o/done_o/err_o = 0; address/count registers = 0.
- Constants on AW/W:
  - awsize = log2(DATA_WIDTH/8); awburst = INCR (2'b01); awcache = 4'b0011.
  - awlock/awprot/awqos/awregion = 0; awid = AXI_ID; wstrb = all ones.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - start_i with total_beats_i≠0: latch address and beat count, busy_o=1, go to ADDR. awvalid is high the next cycle.
  - start_i with total_beats_i=0: no AXI traffic; done_o pulses the next cycle with err_o=0; stay in IDLE.
- Burst length: len = min(remaining, MAX_BURST_LEN, beats to next 4 KB boundary), where the boundary term is (4096 − addr[11:0]) >> log2(DATA_WIDTH/8). Registered on entry to ADDR; awlen = len−1.
- ADDR:
  - awvalid=1 with awaddr/awlen held stable until awready.
  - On handshake go to DATA. No W beat is issued before the AW handshake.
- DATA:
  - m_axi_wvalid = s_valid_i; s_ready_o = m_axi_wready; wdata = s_data_i.
  - The stream source must obey the AXI valid/ready hold rule.
  - A beat transfers when wvalid&wready; beat counter increments.
  - wlast=1 only on beat len−1. After that handshake go to RESP.
- RESP:
  - bready=1; on bvalid, capture the error flag (bresp≠2'b00 or bid≠AXI_ID).
  - Error, or remaining=0: go to IDLE, busy_o=0, done_o=1 (and err_o=1 if errored) in the same cycle as the exit.
  - Otherwise: addr += len·(DATA_WIDTH/8), remaining −= len, go to ADDR.
  - On error, no further bursts are issued (abort after the current response).
- At most one outstanding burst at any time.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; no error is flagged for wrap.
- Reset mid-operation: all valids/readys drop asynchronously, the job is discarded, and no done_o is produced.
- s_ready_o=0 outside DATA; stream data is never dropped or duplicated.

Decomposition:
- Package scc_axi_pkg:
  - burst_e (FIXED/INCR/WRAP) and resp_e (OKAY/EXOKAY/SLVERR/DECERR) typedefs.
  - Constants AXI_BOUNDARY_BYTES=4096 and AXI_CACHE_DEFAULT=4'b0011.
  - FSM state typedef wr_state_e.
- Sub-module scc_axi_burst_calc: combinational min(remaining, MAX_BURST_LEN, 4 KB room) → len. Reused by the future read master.

Test Plan:
- base 0x0000_1000, 40 beats, MAX 16, ready always high → AW at 0x1000/0x1100/0x1200 with awlen 15/15/7; 40 W beats in order; wlast on beats 16/32/40; done_o one pulse on third B, err_o=0.
- base 0x0000_1FC0, 8 beats → awlen 3 at 0x1FC0, then awlen 3 at 0x2000; no burst crosses 0x2000.
- total_beats_i=0 → no awvalid; done_o high exactly one cycle after start_i; busy_o stays 0.
- 40-beat job, first BRESP=SLVERR → no second AW; done_o and err_o pulse together on that B; busy_o drops.
- awready low 5 cycles, wready toggling, gaps in s_valid_i → awaddr/awlen stable while awvalid; data order preserved; start_i while busy ignored.
- rst_ni asserted mid-DATA (beat 7 of 16) → awvalid/wvalid/bready/busy_o low immediately, no done_o; a new 4-beat job after release completes normally.
